// File: rtl/cmp_pkg.sv
// Shared result encoding for the cascadable magnitude comparator.
// Flags are carried as a one-hot {lt, eq, gt} vector.
package cmp_pkg;

  typedef enum logic [1:0] {
    CMP_LT,
    CMP_EQ,
    CMP_GT
  } cmp_res_t;

  localparam logic [2:0] FLAGS_LT = 3'b100;
  localparam logic [2:0] FLAGS_EQ = 3'b010;
  localparam logic [2:0] FLAGS_GT = 3'b001;

  function automatic logic [2:0] to_flags(cmp_res_t res);
    logic [2:0] flags;
    case (res)
      CMP_LT:  flags = FLAGS_LT;
      CMP_GT:  flags = FLAGS_GT;
      default: flags = FLAGS_EQ;
    endcase
    return flags;
  endfunction

endpackage

// File: rtl/mag_cmp_bit.sv
// One bit of the MSB-first compare chain.
// A decision made by a higher bit passes through; on a tie so far, this bit decides.
module mag_cmp_bit
  import cmp_pkg::*;
(
  input  logic       a_i,
  input  logic       b_i,
  input  logic [2:0] flags_in,
  output logic [2:0] flags_out
);

  always_comb begin
    flags_out = flags_in;
    if (flags_in == FLAGS_EQ) begin
      if (a_i && !b_i)      flags_out = FLAGS_GT;
      else if (!a_i && b_i) flags_out = FLAGS_LT;
    end
  end

endmodule

// File: rtl/mag_cmp_cascade.sv
// Registered, cascadable unsigned magnitude comparator (7485-style).
// Local compare wins when operands differ; otherwise the lower stage's cascade decides.
module mag_cmp_cascade
  import cmp_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             casc_lt,
  input  logic             casc_eq,
  input  logic             casc_gt,
  output logic             out_valid,
  output logic             lt,
  output logic             eq,
  output logic             gt
);

  logic [WIDTH:0][2:0] chain;
  logic [2:0]          local_flags;
  logic [2:0]          next_flags;

  assign chain[WIDTH] = to_flags(CMP_EQ);

  for (genvar i = WIDTH - 1; i >= 0; i--) begin : g_cell
    mag_cmp_bit u_bit (
      .a_i      (a[i]),
      .b_i      (b[i]),
      .flags_in (chain[i+1]),
      .flags_out(chain[i])
    );
  end

  assign local_flags = chain[0];

  // Illegal cascade combinations (lt and gt both or neither) resolve to eq.
  always_comb begin
    next_flags = local_flags;
    if (local_flags == FLAGS_EQ) begin
      if (casc_eq)                  next_flags = to_flags(CMP_EQ);
      else if (casc_lt && !casc_gt) next_flags = to_flags(CMP_LT);
      else if (casc_gt && !casc_lt) next_flags = to_flags(CMP_GT);
      else                          next_flags = to_flags(CMP_EQ);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      lt        <= 1'b0;
      eq        <= 1'b0;
      gt        <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        lt <= next_flags[2];
        eq <= next_flags[1];
        gt <= next_flags[0];
      end
    end
  end

endmodule

// File: tb/tb_mag_cmp_cascade.sv
// Scoreboard bench for mag_cmp_cascade: directed and random operands against an
// arithmetic reference model; a negedge monitor pops expected flags on out_valid.
module tb_mag_cmp_cascade;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             casc_lt = 1'b0;
  logic             casc_eq = 1'b1;
  logic             casc_gt = 1'b0;
  logic             out_valid;
  logic             lt, eq, gt;

  int checks = 0;
  int failures = 0;

  logic [2:0] exp_q[$];
  logic [2:0] last_flags = 3'b000;

  mag_cmp_cascade #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .casc_lt  (casc_lt),
    .casc_eq  (casc_eq),
    .casc_gt  (casc_gt),
    .out_valid(out_valid),
    .lt       (lt),
    .eq       (eq),
    .gt       (gt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %b, expected %b at t=%0t", name, got, want, $time);
    end
  endtask

  // Reference: numeric comparison first, cascade only on a tie.
  function automatic logic [2:0] model(input int unsigned av, input int unsigned bv,
                                       input bit cl, input bit ce, input bit cg);
    if (av > bv) return 3'b001;
    if (av < bv) return 3'b100;
    if (ce) return 3'b010;
    if (cl && !cg) return 3'b100;
    if (cg && !cl) return 3'b001;
    return 3'b010;
  endfunction

  task automatic send(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                      input logic [2:0] casc);
    @(posedge clk); #1;
    in_valid = 1'b1;
    a = av; b = bv;
    {casc_lt, casc_eq, casc_gt} = casc;
    exp_q.push_back(model(av, bv, casc[2], casc[1], casc[0]));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = WIDTH'($urandom);
      b = WIDTH'($urandom);
      {casc_lt, casc_eq, casc_gt} = 3'($urandom);
    end
  endtask

  task automatic drain();
    int budget = 20;
    while (exp_q.size() != 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      last_flags = 3'b000;
    end else if (out_valid) begin
      check("onehot", {1'b0, 3'((lt ? 1 : 0) + (eq ? 1 : 0) + (gt ? 1 : 0))}, 4'd1);
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_valid: got out_valid=1, expected no result pending");
      end else begin
        last_flags = exp_q.pop_front();
        check("flags", {1'b0, lt, eq, gt}, {1'b0, last_flags});
      end
    end else begin
      check("hold", {1'b0, lt, eq, gt}, {1'b0, last_flags});
    end
  end

  initial begin
    #1;
    check("reset_init", {out_valid, lt, eq, gt}, 4'b0000);
    #22 rst_n = 1'b1;

    send(4'h1, 4'h0, 3'b010);
    idle(1);

    for (int i = 0; i < 4; i++) send(4'h1, 4'(i * 4), 3'b010);
    send(4'h8, 4'h8, 3'b010);

    send(4'h5, 4'h5, 3'b100);
    send(4'h5, 4'h5, 3'b001);
    send(4'h5, 4'h5, 3'b011);
    send(4'h5, 4'h5, 3'b000);
    send(4'h5, 4'h5, 3'b101);
    send(4'h5, 4'h5, 3'b111);

    send(4'hF, 4'hE, 3'b100);
    send(4'h0, 4'hF, 3'b001);
    send(4'h0, 4'h0, 3'b010);
    send(4'hF, 4'h0, 3'b100);
    send(4'h6, 4'h7, 3'b001);
    send(4'h7, 4'h6, 3'b100);

    send(4'h3, 4'h7, 3'b010);
    idle(2);
    check("hold_lt", {out_valid, lt, eq, gt}, 4'b0100);
    idle(1);
    drain();

    // Mid-stream reset: the in-flight sample must never produce a result.
    @(posedge clk); #1;
    in_valid = 1'b1; a = 4'h1; b = 4'h0; {casc_lt, casc_eq, casc_gt} = 3'b010;
    #3 rst_n = 1'b0;
    #1 check("reset_async", {out_valid, lt, eq, gt}, 4'b0000);
    #1 in_valid = 1'b0;
    @(posedge clk); #1;
    check("reset_held", {out_valid, lt, eq, gt}, 4'b0000);
    @(negedge clk); #2 rst_n = 1'b1;
    send(4'h1, 4'h0, 3'b010);
    check("post_reset_not_yet", {3'b000, out_valid}, 4'b0000);
    @(posedge clk); #1;
    check("post_reset_latency", {out_valid, lt, eq, gt}, 4'b1001);
    in_valid = 1'b0;
    drain();

    for (int i = 0; i < 300; i++) begin
      logic [WIDTH-1:0] ra, rb;
      ra = WIDTH'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : WIDTH'($urandom);
      if ($urandom_range(0, 7) == 0) rb = ra ^ 4'h1;
      send(ra, rb, 3'($urandom));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
